// File: rtl/i2c_pkg.sv
// i2c_pkg: FSM state encoding, register-file sizing and the majority helper shared by the I2C target.
package i2c_pkg;
  localparam int NUM_REGS = 8;
  localparam int PTR_W = 3;
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE} state_t;
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/i2c_line_filter.sv
// i2c_line_filter: 2-flop synchronizer for one bus line; I2C_TARGET_GLITCH_FILTER_EN adds a
// 3-sample majority stage (+2 clk) that rejects pulses of one clk or less.
module i2c_line_filter (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);
  logic [1:0] sync;
  always_ff @(posedge clk or posedge rst)
    if (rst) sync <= 2'b11;
    else sync <= {sync[0], din};
`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [1:0] hist;
  logic filt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hist <= 2'b11;
      filt <= 1'b1;
    end else begin
      hist <= {hist[0], sync[1]};
      filt <= i2c_pkg::maj3(sync[1], hist[0], hist[1]);
    end
  assign dout = filt;
`else
  assign dout = sync[1];
`endif
endmodule

// File: rtl/i2c_target.sv
// i2c_target: I2C target with 4 writable control registers and 4 read-only status registers.
// Optional SCL/SDA glitch filtering is enabled with I2C_TARGET_GLITCH_FILTER_EN.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h42
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  output logic [31:0] ctrl_regs,
  input  logic [31:0] status_in,
  output logic        wr_strobe,
  output logic        busy
);
  logic scl, sda, scl_q, sda_q;
  logic scl_rise, scl_fall, start, stop, addr_hit, load_rd;
  state_t state, state_d;
  logic [3:0] cnt, cnt_d;
  logic [7:0] sr, sr_d, rd_data;
  logic [PTR_W-1:0] ptr, ptr_d;
  logic [NUM_REGS/2-1:0][7:0] regs, regs_d;
  logic first, first_d, oe_d, busy_d, strobe_d;

  i2c_line_filter u_scl (.clk(clk), .rst(reset), .din(scl_in), .dout(scl));
  i2c_line_filter u_sda (.clk(clk), .rst(reset), .din(sda_in), .dout(sda));

  assign scl_rise  = scl & ~scl_q;
  assign scl_fall  = ~scl & scl_q;
  assign start     = scl & scl_q & sda_q & ~sda;
  assign stop      = scl & scl_q & ~sda_q & sda;
  assign addr_hit  = sr[7:1] == DEV_ADDR;
  assign rd_data   = ptr[2] ? status_in[{ptr[1:0], 3'b000} +: 8] : regs[ptr[1:0]];
  assign ctrl_regs = regs;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      sr        <= '0;
      ptr       <= '0;
      regs      <= '0;
      first     <= 1'b0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      wr_strobe <= 1'b0;
      scl_q     <= 1'b1;
      sda_q     <= 1'b1;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      sr        <= sr_d;
      ptr       <= ptr_d;
      regs      <= regs_d;
      first     <= first_d;
      sda_oe    <= oe_d;
      busy      <= busy_d;
      wr_strobe <= strobe_d;
      scl_q     <= scl;
      sda_q     <= sda;
    end

  // START/STOP override any bit activity; sda_oe otherwise only moves on SCL falls
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    sr_d     = sr;
    ptr_d    = ptr;
    regs_d   = regs;
    first_d  = first;
    oe_d     = sda_oe;
    busy_d   = busy;
    strobe_d = 1'b0;
    load_rd  = 1'b0;
    if (start) begin
      state_d = ADDR;
      cnt_d   = '0;
      first_d = 1'b1;
      oe_d    = 1'b0;
    end else if (stop) begin
      state_d = IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else
      case (state)
        ADDR:
          if (scl_rise) begin
            sr_d  = {sr[6:0], sda};
            cnt_d = cnt + 1'b1;
          end else if (scl_fall && cnt == 4'd8) begin
            state_d = addr_hit ? ADDR_ACK : IGNORE;
            oe_d    = addr_hit;
            busy_d  = busy | addr_hit;
          end
        ADDR_ACK:
          if (scl_fall) begin
            load_rd = sr[0];
            state_d = WR_BYTE;
            oe_d    = 1'b0;
            cnt_d   = '0;
          end
        WR_BYTE:
          if (scl_rise) begin
            sr_d  = {sr[6:0], sda};
            cnt_d = cnt + 1'b1;
          end else if (scl_fall && cnt == 4'd8) begin
            state_d = WR_ACK;
            oe_d    = 1'b1;
            cnt_d   = '0;
            first_d = 1'b0;
            ptr_d   = first ? sr[PTR_W-1:0] : ptr + 1'b1;
            if (!first && !ptr[2]) begin
              regs_d[ptr[1:0]] = sr;
              strobe_d         = 1'b1;
            end
          end
        WR_ACK:
          if (scl_fall) begin
            state_d = WR_BYTE;
            oe_d    = 1'b0;
          end
        RD_BYTE:
          if (scl_rise) cnt_d = cnt + 1'b1;
          else if (scl_fall) begin
            state_d = cnt == 4'd8 ? RD_ACK : RD_BYTE;
            oe_d    = cnt == 4'd8 ? 1'b0 : ~sr[6];
            sr_d    = {sr[6:0], 1'b0};
          end
        RD_ACK:
          if (scl_rise && sda) state_d = IGNORE;
          else if (scl_fall) load_rd = 1'b1;
        default: ;
      endcase
    if (load_rd) begin
      state_d = RD_BYTE;
      sr_d    = rd_data;
      ptr_d   = ptr + 1'b1;
      oe_d    = ~rd_data[7];
      cnt_d   = '0;
    end
  end
endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: bus-level master driving directed and random transactions; a scoreboard
// compares ACKs, read bytes and write strobes against a register-file reference model.
`timescale 1ns/1ps
module tb_i2c_target;
  import i2c_pkg::*;
  localparam int Q = 8;
  typedef struct {string tag; int val;} item_t;

  logic clk = 1'b0, reset = 1'b1, scl_m = 1'b1, sda_m = 1'b1;
  logic [31:0] status_in = '0;
  logic sda_oe, wr_strobe, busy, sda_bus;
  logic [31:0] ctrl_regs;
  item_t exp_q[$], obs_q[$], mo, me;
  int exp_wr[$];
  logic [7:0] wbuf[$];
  int n_cmp = 0, n_bad = 0, w;
  logic oe_seen = 1'b0, busy_seen = 1'b0;
  logic [7:0] mregs[4] = '{default: 8'h00};
  int mptr = 0;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_target dut (
    .clk(clk), .reset(reset), .scl_in(scl_m), .sda_in(sda_bus), .sda_oe(sda_oe),
    .ctrl_regs(ctrl_regs), .status_in(status_in), .wr_strobe(wr_strobe), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  function automatic item_t mk(input string t, input int v);
    mk.tag = t;
    mk.val = v;
  endfunction

  function automatic logic [31:0] mpacked();
    return {mregs[3], mregs[2], mregs[1], mregs[0]};
  endfunction

  function automatic void model_write();
    foreach (wbuf[i])
      if (i == 0) mptr = wbuf[0] % 8;
      else begin
        if (mptr < 4) begin
          mregs[mptr] = wbuf[i];
          exp_wr.push_back(mptr * 256 + int'(wbuf[i]));
        end
        mptr = (mptr + 1) % 8;
      end
  endfunction

  function automatic int model_read();
    int v = mptr < 4 ? int'(mregs[mptr]) : int'((status_in >> (8 * (mptr - 4))) & 32'hFF);
    mptr = (mptr + 1) % 8;
    return v;
  endfunction

  always @(negedge clk) begin
    if (busy) busy_seen = 1'b1;
    if (sda_oe) oe_seen = 1'b1;
    while (obs_q.size() > 0) begin
      mo = obs_q.pop_front();
      me = exp_q.size() > 0 ? exp_q.pop_front() : mk("none", -1);
      check({"sb ", mo.tag, "/", me.tag}, mo.val, me.val);
    end
    if (wr_strobe) begin
      w = exp_wr.size() > 0 ? exp_wr.pop_front() : -1;
      if (w < 0) check("wr_strobe unexpected", 1, 0);
      else check("wr_strobe reg", ctrl_regs[8 * (w / 256) +: 8], w % 256);
    end
  end

  task automatic qw();
    repeat (Q) @(negedge clk);
  endtask

  task automatic clk_bit(input logic b, input logic glitch, output logic s);
    qw(); sda_m = b; qw(); scl_m = 1'b1; qw();
    if (glitch) begin
      scl_m = 1'b0;
      @(negedge clk);
      scl_m = 1'b1;
    end
    s = sda_bus; qw(); scl_m = 1'b0;
  endtask

  task automatic do_start();
    sda_m = 1'b1; qw(); scl_m = 1'b1; qw(); sda_m = 1'b0; qw(); scl_m = 1'b0;
  endtask

  task automatic stop_bus();
    qw(); sda_m = 1'b0; qw(); scl_m = 1'b1; qw(); sda_m = 1'b1; qw();
  endtask

  task automatic wr_byte(input logic [7:0] b, input bit acked);
    logic s;
    exp_q.push_back(mk("ack", acked ? 0 : 1));
    for (int i = 7; i >= 0; i--) clk_bit(b[i], 1'b0, s);
    clk_bit(1'b1, 1'b0, s);
    obs_q.push_back(mk("ack", int'(s)));
  endtask

  task automatic rd_byte(input logic nack);
    logic s;
    logic [7:0] v;
    exp_q.push_back(mk("rd", model_read()));
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, 1'b0, s);
      v[i] = s;
    end
    clk_bit(nack, 1'b0, s);
    obs_q.push_back(mk("rd", int'(v)));
  endtask

  task automatic write_tx(input bit with_stop);
    do_start();
    wr_byte(8'h84, 1'b1);
    model_write();
    foreach (wbuf[i]) wr_byte(wbuf[i], 1'b1);
    if (with_stop) stop_bus();
  endtask

  task automatic read_tx(input int n);
    do_start();
    wr_byte(8'h85, 1'b1);
    for (int i = 0; i < n; i++) rd_byte(i == n - 1);
    stop_bus();
  endtask

  task automatic settle(input string name);
    repeat (4) @(negedge clk);
    check({name, " pending"}, exp_q.size(), 0);
    check({name, " strobes"}, exp_wr.size(), 0);
    check({name, " regs"}, ctrl_regs, mpacked());
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic s;
    logic [6:0] a;
    repeat (3) @(negedge clk);
    check("rst sda_oe", sda_oe, 0);
    check("rst busy", busy, 0);
    check("rst wr_strobe", wr_strobe, 0);
    check("rst ctrl_regs", ctrl_regs, 0);
    check("rst state", dut.state, IDLE);
    reset = 1'b0;
    qw();

    wbuf = '{8'h01, 8'hA5, 8'h5A};
    write_tx(1'b0);
    check("busy in txn", busy, 1);
    stop_bus();
    check("busy after stop", busy, 0);
    settle("write4");
    check("R1/R2", ctrl_regs[23:8], 16'h5AA5);

    status_in = 32'h11223344;
    wbuf = '{8'h04};
    write_tx(1'b0);
    do_start();
    wr_byte(8'h85, 1'b1);
    rd_byte(1'b0); rd_byte(1'b0); rd_byte(1'b1);
    qw();
    check("state after nack", dut.state, IGNORE);
    stop_bus();
    check("state after stop", dut.state, IDLE);
    settle("rstart read");

    oe_seen = 1'b0; busy_seen = 1'b0;
    do_start();
    wr_byte(8'h90, 1'b0);
    wr_byte(8'h55, 1'b0);
    stop_bus();
    check("foreign oe", oe_seen, 0);
    check("foreign busy", busy_seen, 0);
    settle("foreign addr");

    wbuf = '{8'h07, 8'hAA, 8'hBB, 8'hCC};
    write_tx(1'b1);
    settle("ptr wrap");

    for (int it = 0; it < 16; it++) begin
      status_in = $urandom;
      case ($urandom_range(0, 3))
        0: begin
          wbuf = {};
          repeat ($urandom_range(1, 5)) wbuf.push_back(8'($urandom));
          write_tx(1'b1);
        end
        1: begin
          wbuf = '{8'($urandom)};
          write_tx(1'b1);
          read_tx($urandom_range(1, 3));
        end
        2: read_tx($urandom_range(1, 3));
        default: begin
          do
            a = 7'($urandom);
          while (a == 7'h42);
          do_start();
          wr_byte({a, 1'($urandom)}, 1'b0);
          stop_bus();
        end
      endcase
      settle("random");
    end

    status_in = 32'h0;
    wbuf = '{8'h04};
    write_tx(1'b1);
    do_start();
    wr_byte(8'h85, 1'b1);
    for (int i = 7; i >= 4; i--) clk_bit(1'b1, 1'b0, s);
    qw(); qw(); scl_m = 1'b1; qw();
    check("oe before reset", sda_oe, 1);
    reset = 1'b1;
    @(negedge clk);
    check("oe after reset", sda_oe, 0);
    mregs = '{default: 8'h00};
    mptr = 0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    qw();
    wbuf = '{8'h00, 8'h3C, 8'hC3};
    write_tx(1'b1);
    settle("after reset");

    wbuf = '{8'h00, 8'h10, 8'h21, 8'h32, 8'h43};
    write_tx(1'b1);
    do_start();
    wr_byte(8'h84, 1'b1);
    for (int i = 7; i >= 0; i--) clk_bit(i == 3 || i > 1 ? 1'b0 : 1'b1, i == 7, s);
    clk_bit(1'b1, 1'b0, s);
    stop_bus();
`ifdef I2C_TARGET_GLITCH_FILTER_EN
    mptr = 3;
`else
    mptr = 1;
`endif
    read_tx(1);
    settle("scl glitch");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
